unified_memory_arbiter: RTL and testbench

- Shares one single-port, synchronous-read block RAM between the RISC-V instruction-fetch requester (I-port) and the load/store requester (D-port).
- Maps the text and data segments into one physical array, with the text segment first and the data segment after it.
- Arbitrates with data priority plus an anti-starvation override for fetch.
- Range-checks and alignment-checks every request and returns read data with fixed one-cycle latency.

---
 rtl/riscv_mem_pkg.sv | 20 ++
 rtl/mem_addr_decode.sv | 20 ++
 rtl/unified_memory_arbiter.sv | 140 ++++++++++++++
 tb/tb_unified_memory_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared constants and types for the unified text/data memory arbiter.
package riscv_mem_pkg;

  localparam logic [31:0] NOP_INSTRUCTION    = 32'h00000013;
  localparam logic [31:0] DEFAULT_TEXT_START = 32'h00000000;
  localparam logic [31:0] DEFAULT_DATA_START = 32'h10010000;

  typedef enum logic [1:0] {
    OWNER_NONE,
    OWNER_I,
    OWNER_D
  } mem_owner_t;

  typedef struct packed {
    mem_owner_t owner;
    logic       is_read;
    logic       fault;
  } mem_tag_t;

endpackage

// File: rtl/mem_addr_decode.sv
// Maps a byte address onto a physical word index and flags misaligned or out-of-range accesses.
module mem_addr_decode #(
  parameter logic [31:0] BASE       = 32'h00000000,
  parameter int unsigned WORDS      = 1024,
  parameter int unsigned INDEX_BASE = 0,
  parameter int unsigned IDX_W      = 11
) (
  input  logic [31:0]      addr,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  logic [31:0] offset;

  // Wrap-around makes an address below BASE look huge, so one compare covers both bounds.
  assign offset = addr - BASE;
  assign valid  = (addr[1:0] == 2'b00) && (offset < (32'(WORDS) << 2));
  assign index  = IDX_W'(offset >> 2) + IDX_W'(INDEX_BASE);

endmodule

// File: rtl/unified_memory_arbiter.sv
// Shares one synchronous-read RAM between instruction fetch and load/store, with data
// priority and a bounded data streak so fetch cannot starve.
module unified_memory_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned TEXT_WORDS      = 1024,
  parameter int unsigned DATA_WORDS      = 256,
  parameter logic [31:0] TEXT_START      = DEFAULT_TEXT_START,
  parameter logic [31:0] DATA_START      = DEFAULT_DATA_START,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      i_req,
  input  logic [31:0]                               i_addr,
  output logic                                      i_gnt,
  output logic                                      i_rvalid,
  output logic [31:0]                               i_rdata,
  output logic                                      i_err,
  input  logic                                      d_req,
  input  logic                                      d_we,
  input  logic [31:0]                               d_addr,
  input  logic [31:0]                               d_wdata,
  output logic                                      d_gnt,
  output logic                                      d_rvalid,
  output logic [31:0]                               d_rdata,
  output logic                                      d_err,
  output logic                                      mem_en,
  output logic                                      mem_we,
  output logic [$clog2(TEXT_WORDS+DATA_WORDS)-1:0]  mem_addr,
  output logic [31:0]                               mem_wdata,
  input  logic [31:0]                               mem_rdata
);

  localparam int unsigned IDX_W    = $clog2(TEXT_WORDS + DATA_WORDS);
  localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);

  logic             i_valid, d_valid;
  logic [IDX_W-1:0] i_index, d_index;
  logic             force_i;
  logic [STREAK_W-1:0] streak_q, streak_d;
  mem_tag_t         tag_q, tag_d;
  logic [31:0]      i_rdata_q, d_rdata_q;
  logic             i_resp, d_load;

  mem_addr_decode #(
    .BASE       (TEXT_START),
    .WORDS      (TEXT_WORDS),
    .INDEX_BASE (0),
    .IDX_W      (IDX_W)
  ) u_i_decode (
    .addr  (i_addr),
    .valid (i_valid),
    .index (i_index)
  );

  mem_addr_decode #(
    .BASE       (DATA_START),
    .WORDS      (DATA_WORDS),
    .INDEX_BASE (TEXT_WORDS),
    .IDX_W      (IDX_W)
  ) u_d_decode (
    .addr  (d_addr),
    .valid (d_valid),
    .index (d_index)
  );

  always_comb begin
    force_i   = (streak_q == STREAK_W'(MAX_DATA_STREAK)) && i_req;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    tag_d     = '{owner: OWNER_NONE, is_read: 1'b0, fault: 1'b0};
    streak_d  = streak_q;
    if (!rst) begin
      mem_wdata = d_wdata;
      if (d_req && !force_i) begin
        d_gnt = 1'b1;
        tag_d = '{owner: OWNER_D, is_read: !d_we, fault: !d_valid};
        if (d_valid) begin
          mem_en   = 1'b1;
          mem_we   = d_we;
          mem_addr = d_index;
        end
      end else if (i_req) begin
        i_gnt = 1'b1;
        tag_d = '{owner: OWNER_I, is_read: 1'b1, fault: !i_valid};
        if (i_valid) begin
          mem_en   = 1'b1;
          mem_addr = i_index;
        end
      end
      if (!i_req || i_gnt) begin
        streak_d = '0;
      end else if (d_gnt && (streak_q != STREAK_W'(MAX_DATA_STREAK))) begin
        streak_d = streak_q + STREAK_W'(1);
      end
    end
  end

  // Responses come straight from the tag so reset kills an in-flight read immediately.
  always_comb begin
    i_resp   = (tag_q.owner == OWNER_I);
    d_load   = (tag_q.owner == OWNER_D) && tag_q.is_read;
    i_rvalid = i_resp;
    i_err    = i_resp && tag_q.fault;
    d_rvalid = d_load;
    d_err    = (tag_q.owner == OWNER_D) && tag_q.fault;
    i_rdata  = i_rdata_q;
    d_rdata  = d_rdata_q;
    if (i_resp) begin
      i_rdata = tag_q.fault ? NOP_INSTRUCTION : mem_rdata;
    end
    if (d_load) begin
      d_rdata = tag_q.fault ? 32'h0 : mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q  <= '0;
      tag_q     <= '{owner: OWNER_NONE, is_read: 1'b0, fault: 1'b0};
      i_rdata_q <= NOP_INSTRUCTION;
      d_rdata_q <= 32'h0;
    end else begin
      streak_q <= streak_d;
      tag_q    <= tag_d;
      if (i_resp) begin
        i_rdata_q <= i_rdata;
      end
      if (d_load) begin
        d_rdata_q <= d_rdata;
      end
    end
  end

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Directed scoreboard bench: stimulus pushes expected responses, a negedge monitor checks them.
module tb_unified_memory_arbiter;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] RAM1 = 32'h00500093;
  localparam logic [31:0] RAM2 = 32'h00208113;
  localparam logic [31:0] CAFE = 32'hCAFEF00D;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_gnt, i_rvalid, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic        pre_we;
  logic [10:0] pre_addr;
  logic [31:0] pre_data;
  logic [31:0] ram [1280];

  typedef struct {
    logic        rvalid;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t iq[$];
  exp_t dq[$];
  int   compared = 0;
  int   mismatched = 0;

  unified_memory_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .i_err     (i_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous-read RAM with a backdoor preload port.
  always @(posedge clk) begin
    if (pre_we) begin
      ram[pre_addr] <= pre_data;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check32(name, {31'h0, act}, {31'h0, exp});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (i_rvalid || i_err) begin
      if (iq.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL i_unexpected: rvalid=%b err=%b rdata=%h, expected no response (t=%0t)",
                 i_rvalid, i_err, i_rdata, $time);
      end else begin
        e = iq.pop_front();
        check1("i_rvalid", i_rvalid, e.rvalid);
        check32("i_rdata", i_rdata, e.data);
        check1("i_err", i_err, e.err);
      end
    end
    if (d_rvalid || d_err) begin
      if (dq.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL d_unexpected: rvalid=%b err=%b rdata=%h, expected no response (t=%0t)",
                 d_rvalid, d_err, d_rdata, $time);
      end else begin
        e = dq.pop_front();
        check1("d_rvalid", d_rvalid, e.rvalid);
        if (e.rvalid) check32("d_rdata", d_rdata, e.data);
        check1("d_err", d_err, e.err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_req = 1'b0;
    d_req = 1'b0;
    d_we  = 1'b0;
  endtask

  task automatic issue_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic ok, input int unsigned idx);
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = addr;
    d_wdata = wdata;
    @(negedge clk);
    check1($sformatf("d_gnt@%h", addr), d_gnt, 1'b1);
    check1($sformatf("d_mem_en@%h", addr), mem_en, ok);
    check1($sformatf("d_mem_we@%h", addr), mem_we, ok & we);
    if (ok) check32($sformatf("d_mem_addr@%h", addr), 32'(mem_addr), 32'(idx));
    tick();
  endtask

  task automatic fetch_first();
    i_req  = 1'b1;
    i_addr = 32'h00000004;
    iq.push_back('{rvalid: 1'b1, data: RAM1, err: 1'b0});
    @(negedge clk);
    check1("f1_i_gnt", i_gnt, 1'b1);
    check1("f1_d_gnt", d_gnt, 1'b0);
    check1("f1_mem_en", mem_en, 1'b1);
    check32("f1_mem_addr", 32'(mem_addr), 32'd1);
    check32("f1_i_rdata_before", i_rdata, NOP);
    tick();
    idle();
    tick();
  endtask

  initial begin
    logic [8:0] d_mask;
    rst = 1'b1;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    tick();
    pre_we = 1'b1; pre_addr = 11'd1; pre_data = RAM1;
    tick();
    pre_addr = 11'd2; pre_data = RAM2;
    tick();
    pre_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    @(negedge clk);
    check1("rst_i_gnt", i_gnt, 1'b0);
    check1("rst_d_gnt", d_gnt, 1'b0);
    check1("rst_mem_en", mem_en, 1'b0);
    check1("rst_i_rvalid", i_rvalid, 1'b0);
    check32("rst_i_rdata", i_rdata, NOP);
    check32("rst_d_rdata", d_rdata, 32'h0);
    tick();
    idle();
    rst = 1'b0;
    tick();

    fetch_first();

    // Store then load of the same word back-to-back.
    issue_d(1'b1, 32'h10010008, CAFE, 1'b1, 1026);
    dq.push_back('{rvalid: 1'b1, data: CAFE, err: 1'b0});
    issue_d(1'b0, 32'h10010008, 32'h0, 1'b1, 1026);
    idle();
    tick();

    // Both ports held: four D grants, one forced I grant, then D again.
    d_mask = 9'b1_1110_1111;
    i_req = 1'b1; i_addr = 32'h00000008;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10010008;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      check1($sformatf("arb_d_gnt_c%0d", c), d_gnt, d_mask[c]);
      check1($sformatf("arb_i_gnt_c%0d", c), i_gnt, !d_mask[c]);
      if (d_mask[c]) begin
        dq.push_back('{rvalid: 1'b1, data: CAFE, err: 1'b0});
      end else begin
        check32("arb_i_mem_addr", 32'(mem_addr), 32'd2);
        iq.push_back('{rvalid: 1'b1, data: RAM2, err: 1'b0});
      end
      tick();
    end
    idle();
    tick();

    // Data faults: misaligned, past the segment, and a misaligned store that must not write.
    dq.push_back('{rvalid: 1'b1, data: 32'h0, err: 1'b1});
    issue_d(1'b0, 32'h10010002, 32'h0, 1'b0, 0);
    dq.push_back('{rvalid: 1'b1, data: 32'h0, err: 1'b1});
    issue_d(1'b0, 32'h10010400, 32'h0, 1'b0, 0);
    dq.push_back('{rvalid: 1'b0, data: 32'h0, err: 1'b1});
    issue_d(1'b1, 32'h1001000A, 32'hDEADBEEF, 1'b0, 0);
    dq.push_back('{rvalid: 1'b1, data: CAFE, err: 1'b0});
    issue_d(1'b0, 32'h10010008, 32'h0, 1'b1, 1026);
    idle();
    tick();
    @(negedge clk);
    check32("d_rdata_hold", d_rdata, CAFE);
    check32("i_rdata_hold", i_rdata, RAM2);
    tick();

    // Fetch past the text segment.
    i_req = 1'b1; i_addr = 32'h00001000;
    iq.push_back('{rvalid: 1'b1, data: NOP, err: 1'b1});
    @(negedge clk);
    check1("ifault_i_gnt", i_gnt, 1'b1);
    check1("ifault_mem_en", mem_en, 1'b0);
    tick();
    idle();
    tick();

    // Reset lands in the response cycle of a load: the response must vanish.
    issue_d(1'b0, 32'h10010008, 32'h0, 1'b1, 1026);
    rst = 1'b1;
    idle();
    @(negedge clk);
    check1("rstmid_d_rvalid", d_rvalid, 1'b0);
    check32("rstmid_d_rdata", d_rdata, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    fetch_first();

    tick();
    tick();
    check32("iq_drained", 32'(iq.size()), 32'd0);
    check32("dq_drained", 32'(dq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
